// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: opcodes, ALU function codes, instruction field positions
// and the ID/EX payload structure used by the decode stage and the ALU.
package risc16_pkg;

  localparam int XLEN   = 16;
  localparam int NREGS  = 8;
  localparam int RIDX_W = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_NAND = 2'b01;
  localparam logic [1:0] FN_LUI  = 2'b10;
  localparam logic [1:0] FN_PASS = 2'b11;

  localparam int OP_LSB = 13;
  localparam int RA_LSB = 10;
  localparam int RB_LSB = 7;
  localparam int RC_LSB = 0;

  typedef struct packed {
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [1:0]        func;
    logic [XLEN-1:0]   store_data;
    logic [RIDX_W-1:0] tgt;
    logic              wb_en;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              jalr;
  } idex_t;

  function automatic logic [XLEN-1:0] sext7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

  // A bubble keeps whatever datapath bits it had but must never cause side effects downstream.
  function automatic idex_t clear_ctrl(input idex_t x);
    idex_t y;
    y        = x;
    y.wb_en  = 1'b0;
    y.mem_rd = 1'b0;
    y.mem_wr = 1'b0;
    y.branch = 1'b0;
    y.jalr   = 1'b0;
    return y;
  endfunction

endpackage

// File: rtl/risc16_regfile.sv
// 8x16 architectural register file: r0 hardwired to zero, three async read ports,
// one synchronous write port with write-through to the readers.
module risc16_regfile
  import risc16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RIDX_W-1:0] ra1,
  input  logic [RIDX_W-1:0] ra2,
  input  logic [RIDX_W-1:0] ra3,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  output logic [XLEN-1:0]   rd3,
  input  logic              we,
  input  logic [RIDX_W-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] regs_r [NREGS];

  // Read with r0 forced to zero and same-cycle writeback forwarded to the reader.
  function automatic logic [XLEN-1:0] rf_read(input logic [RIDX_W-1:0] idx);
    logic [XLEN-1:0] val;
    if (idx == 3'd0) begin
      val = 16'h0000;
    end else if (we && (idx == wa)) begin
      val = wd;
    end else begin
      val = regs_r[idx];
    end
    return val;
  endfunction

  // Register storage; writes to r0 are discarded so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else if (we && (wa != 3'd0)) begin
      regs_r[wa] <= wd;
    end
  end

  // Three combinational read ports.
  always_comb begin
    rd1 = rf_read(ra1);
    rd2 = rf_read(ra2);
    rd3 = rf_read(ra3);
  end

endmodule

// File: rtl/risc16_decode_stage.sv
// RiSC-16 decode stage: decodes the instruction in ID, reads operands from the register
// file and loads the ID/EX register, honouring flush over stall over normal load.
module risc16_decode_stage
  import risc16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic [15:0] id_pc,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        ex_valid,
  output logic [15:0] ex_src1,
  output logic [15:0] ex_src2,
  output logic [1:0]  ex_func,
  output logic [15:0] ex_store_data,
  output logic [2:0]  ex_tgt,
  output logic        ex_wb_en,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_branch,
  output logic        ex_jalr,
  output logic [15:0] ex_pc
);

  logic [2:0]  op_s;
  logic [2:0]  ra_s;
  logic [2:0]  rb_s;
  logic [2:0]  rc_s;
  logic [6:0]  imm7_s;
  logic [9:0]  imm10_s;
  logic [2:0]  rsel1_s;
  logic [2:0]  rsel2_s;
  logic [15:0] rd1_s;
  logic [15:0] rd2_s;
  logic [15:0] rd3_s;
  logic        wr_cand_s;
  idex_t       dec_s;
  idex_t       ex_r;
  logic        ex_valid_r;
  logic [15:0] ex_pc_r;

  assign op_s    = id_instr[OP_LSB +: 3];
  assign ra_s    = id_instr[RA_LSB +: 3];
  assign rb_s    = id_instr[RB_LSB +: 3];
  assign rc_s    = id_instr[RC_LSB +: 3];
  assign imm7_s  = id_instr[6:0];
  assign imm10_s = id_instr[9:0];

  // BEQ compares regA with regB; every other format reads regB and regC.
  always_comb begin
    rsel1_s = rb_s;
    rsel2_s = rc_s;
    case (op_s)
      OP_BEQ: begin
        rsel1_s = ra_s;
        rsel2_s = rb_s;
      end
      default: begin
        rsel1_s = rb_s;
        rsel2_s = rc_s;
      end
    endcase
  end

  risc16_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rsel1_s),
    .ra2   (rsel2_s),
    .ra3   (ra_s),
    .rd1   (rd1_s),
    .rd2   (rd2_s),
    .rd3   (rd3_s),
    .we    (wb_we),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  // Opcode decode into ALU operands and control; r0 as target never writes back.
  always_comb begin
    dec_s            = '0;
    wr_cand_s        = 1'b0;
    dec_s.src1       = rd1_s;
    dec_s.src2       = rd2_s;
    dec_s.func       = FN_ADD;
    dec_s.store_data = rd3_s;
    dec_s.tgt        = ra_s;
    case (op_s)
      OP_ADD:  wr_cand_s = 1'b1;
      OP_ADDI: begin
        dec_s.src2 = sext7(imm7_s);
        wr_cand_s  = 1'b1;
      end
      OP_NAND: begin
        dec_s.func = FN_NAND;
        wr_cand_s  = 1'b1;
      end
      OP_LUI: begin
        dec_s.src1 = 16'h0000;
        dec_s.src2 = {imm10_s, 6'b000000};
        dec_s.func = FN_LUI;
        wr_cand_s  = 1'b1;
      end
      OP_SW: begin
        dec_s.src2   = sext7(imm7_s);
        dec_s.mem_wr = 1'b1;
      end
      OP_LW: begin
        dec_s.src2   = sext7(imm7_s);
        dec_s.mem_rd = 1'b1;
        wr_cand_s    = 1'b1;
      end
      OP_BEQ: begin
        dec_s.func   = FN_PASS;
        dec_s.branch = 1'b1;
      end
      OP_JALR: begin
        dec_s.src2 = 16'h0000;
        dec_s.func = FN_PASS;
        dec_s.jalr = 1'b1;
        wr_cand_s  = 1'b1;
      end
      default: wr_cand_s = 1'b0;
    endcase
    dec_s.wb_en = wr_cand_s && (ra_s != 3'd0);
  end

  // ID/EX register: flush beats stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r       <= '0;
      ex_valid_r <= 1'b0;
      ex_pc_r    <= 16'h0000;
    end else if (flush) begin
      ex_r       <= clear_ctrl(ex_r);
      ex_valid_r <= 1'b0;
    end else if (!stall) begin
      ex_r       <= id_valid ? dec_s : clear_ctrl(dec_s);
      ex_valid_r <= id_valid;
      ex_pc_r    <= id_pc;
    end
  end

  assign ex_valid      = ex_valid_r;
  assign ex_src1       = ex_r.src1;
  assign ex_src2       = ex_r.src2;
  assign ex_func       = ex_r.func;
  assign ex_store_data = ex_r.store_data;
  assign ex_tgt        = ex_r.tgt;
  assign ex_wb_en      = ex_r.wb_en;
  assign ex_mem_rd     = ex_r.mem_rd;
  assign ex_mem_wr     = ex_r.mem_wr;
  assign ex_branch     = ex_r.branch;
  assign ex_jalr       = ex_r.jalr;
  assign ex_pc         = ex_pc_r;

endmodule

// File: tb/tb_risc16_decode_stage.sv
// Self-checking bench for risc16_decode_stage: a reference model predicts the ID/EX
// contents for each driven cycle, queues them, and compares after the clock edge.
module tb_risc16_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic [15:0] ex_src1;
  logic [15:0] ex_src2;
  logic [1:0]  ex_func;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_tgt;
  logic        ex_wb_en;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_branch;
  logic        ex_jalr;
  logic [15:0] ex_pc;

  risc16_decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .stall         (stall),
    .flush         (flush),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .ex_valid      (ex_valid),
    .ex_src1       (ex_src1),
    .ex_src2       (ex_src2),
    .ex_func       (ex_func),
    .ex_store_data (ex_store_data),
    .ex_tgt        (ex_tgt),
    .ex_wb_en      (ex_wb_en),
    .ex_mem_rd     (ex_mem_rd),
    .ex_mem_wr     (ex_mem_wr),
    .ex_branch     (ex_branch),
    .ex_jalr       (ex_jalr),
    .ex_pc         (ex_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [1:0]  func;
    logic [15:0] sd;
    logic [2:0]  tgt;
    logic        wb;
    logic        rd;
    logic        wr;
    logic        br;
    logic        jl;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ex_m;
  logic [15:0] rf_m [8];
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc_rrr(input int op, input int a, input int b, input int c);
    logic [15:0] w;
    w = {op[2:0], a[2:0], b[2:0], 4'b0000, c[2:0]};
    return w;
  endfunction

  function automatic logic [15:0] enc_rri(input int op, input int a, input int b, input int imm);
    logic [15:0] w;
    w = {op[2:0], a[2:0], b[2:0], imm[6:0]};
    return w;
  endfunction

  function automatic logic [15:0] enc_ri(input int op, input int a, input int imm);
    logic [15:0] w;
    w = {op[2:0], a[2:0], imm[9:0]};
    return w;
  endfunction

  function automatic logic [15:0] mread(input logic [2:0] idx, input logic we,
                                        input logic [2:0] wa, input logic [15:0] wd);
    if (idx == 3'd0) return 16'h0000;
    if (we && wa == idx) return wd;
    return rf_m[idx];
  endfunction

  function automatic exp_t ref_decode(input logic [15:0] ins, input logic [15:0] pc,
                                      input logic we, input logic [2:0] wa, input logic [15:0] wd);
    exp_t        e;
    logic [2:0]  a, b, c;
    logic [15:0] r_a, r_b, r_c, simm;
    a    = ins[12:10];
    b    = ins[9:7];
    c    = ins[2:0];
    r_a  = mread(a, we, wa, wd);
    r_b  = mread(b, we, wa, wd);
    r_c  = mread(c, we, wa, wd);
    simm = ins[6] ? {9'h1FF, ins[6:0]} : {9'h000, ins[6:0]};
    e = '{valid: 1'b1, src1: r_b, src2: r_c, func: 2'd0, sd: r_a, tgt: a,
          wb: 1'b0, rd: 1'b0, wr: 1'b0, br: 1'b0, jl: 1'b0, pc: pc};
    case (ins[15:13])
      3'd0: e.wb = 1'b1;
      3'd1: begin e.src2 = simm; e.wb = 1'b1; end
      3'd2: begin e.func = 2'd1; e.wb = 1'b1; end
      3'd3: begin e.src1 = 16'h0000; e.src2 = {ins[9:0], 6'b000000}; e.func = 2'd2; e.wb = 1'b1; end
      3'd4: begin e.src2 = simm; e.wr = 1'b1; end
      3'd5: begin e.src2 = simm; e.rd = 1'b1; e.wb = 1'b1; end
      3'd6: begin e.src1 = r_a; e.src2 = r_b; e.func = 2'd3; e.br = 1'b1; end
      default: begin e.src2 = 16'h0000; e.func = 2'd3; e.jl = 1'b1; e.wb = 1'b1; end
    endcase
    if (a == 3'd0) e.wb = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0000;
    ex_m = '{valid: 1'b0, src1: 16'h0, src2: 16'h0, func: 2'd0, sd: 16'h0, tgt: 3'd0,
             wb: 1'b0, rd: 1'b0, wr: 1'b0, br: 1'b0, jl: 1'b0, pc: 16'h0};
  endtask

  task automatic compare(input exp_t e);
    check("valid",  {31'd0, ex_valid},  {31'd0, e.valid});
    check("wb_en",  {31'd0, ex_wb_en},  {31'd0, e.wb});
    check("mem_rd", {31'd0, ex_mem_rd}, {31'd0, e.rd});
    check("mem_wr", {31'd0, ex_mem_wr}, {31'd0, e.wr});
    check("branch", {31'd0, ex_branch}, {31'd0, e.br});
    check("jalr",   {31'd0, ex_jalr},   {31'd0, e.jl});
    if (e.valid) begin
      check("src1", {16'd0, ex_src1}, {16'd0, e.src1});
      check("src2", {16'd0, ex_src2}, {16'd0, e.src2});
      check("func", {30'd0, ex_func}, {30'd0, e.func});
      check("tgt",  {29'd0, ex_tgt},  {29'd0, e.tgt});
      check("pc",   {16'd0, ex_pc},   {16'd0, e.pc});
      if (e.wr) check("store_data", {16'd0, ex_store_data}, {16'd0, e.sd});
    end
  endtask

  // One clock: drive inputs, predict ID/EX, clock, then compare against the queued prediction.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic st, input logic fl,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd);
    exp_t dec;
    exp_t got_e;
    id_valid = v;  id_instr = ins;  id_pc = pc;
    stall = st;    flush = fl;
    wb_we = we;    wb_addr = wa;    wb_data = wd;
    dec = ref_decode(ins, pc, we, wa, wd);
    if (fl) begin
      ex_m.valid = 1'b0;
      ex_m.wb = 1'b0; ex_m.rd = 1'b0; ex_m.wr = 1'b0; ex_m.br = 1'b0; ex_m.jl = 1'b0;
    end else if (!st) begin
      ex_m = dec;
      ex_m.valid = v;
      if (!v) begin
        ex_m.wb = 1'b0; ex_m.rd = 1'b0; ex_m.wr = 1'b0; ex_m.br = 1'b0; ex_m.jl = 1'b0;
      end
    end
    exp_q.push_back(ex_m);
    @(posedge clk);
    #1;
    if (we && wa != 3'd0) rf_m[wa] = wd;
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 32'd0, 32'd1);
    end else begin
      got_e = exp_q.pop_front();
      compare(got_e);
    end
  endtask

  task automatic wr_reg(input logic [2:0] wa, input logic [15:0] wd);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, wa, wd);
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] pc);
    cycle(1'b1, ins, pc, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    id_valid = 1'b0; id_instr = 16'h0000; id_pc = 16'h0000;
    stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    compare(ex_m);

    wr_reg(3'd1, 16'h0005);
    wr_reg(3'd2, 16'hFFFF);
    wr_reg(3'd5, 16'hBEEF);
    wr_reg(3'd6, 16'h0100);
    wr_reg(3'd7, 16'hAAAA);

    issue(enc_rrr(0, 3, 1, 2), 16'h0010);
    check("add_src1_const", {16'd0, ex_src1}, 32'h0005);
    check("add_src2_const", {16'd0, ex_src2}, 32'hFFFF);
    check("add_wb_const",   {31'd0, ex_wb_en}, 32'd1);
    issue(enc_rri(1, 1, 1, 7'h7F), 16'h0011);
    check("addi_src2_const", {16'd0, ex_src2}, 32'hFFFF);
    issue(enc_ri(3, 2, 10'h3FF), 16'h0012);
    check("lui_src2_const", {16'd0, ex_src2}, 32'hFFC0);
    check("lui_func_const", {30'd0, ex_func}, 32'd2);
    issue(enc_rrr(0, 0, 1, 2), 16'h0013);
    check("add_r0_wb_const", {31'd0, ex_wb_en}, 32'd0);

    cycle(1'b1, enc_rrr(2, 4, 2, 2), 16'h0014, 1'b0, 1'b0, 1'b1, 3'd2, 16'h1234);
    check("bypass_src1_const", {16'd0, ex_src1}, 32'h1234);
    check("bypass_src2_const", {16'd0, ex_src2}, 32'h1234);

    for (int i = 0; i < 3; i++)
      cycle(1'b1, enc_rrr(0, 5, 6, 7), 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b1, 3'd7, 16'h7777);
    check("stall_pc_const", {16'd0, ex_pc}, 32'h0014);
    issue(enc_rrr(0, 1, 7, 0), 16'h0015);
    check("stall_write_const", {16'd0, ex_src1}, 32'h7777);

    cycle(1'b1, enc_rrr(0, 1, 1, 1), 16'h0016, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000);
    check("flush_stall_valid_const", {31'd0, ex_valid}, 32'd0);
    issue(enc_rrr(0, 1, 1, 1), 16'h0017);
    cycle(1'b1, enc_rrr(0, 2, 1, 1), 16'h0018, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000);

    issue(enc_rri(4, 5, 6, 3), 16'h0020);
    check("sw_src1_const", {16'd0, ex_src1}, 32'h0100);
    check("sw_src2_const", {16'd0, ex_src2}, 32'h0003);
    check("sw_sd_const",   {16'd0, ex_store_data}, 32'hBEEF);
    issue(enc_rri(6, 1, 1, 5), 16'h0021);
    check("beq_branch_const", {31'd0, ex_branch}, 32'd1);
    wr_reg(3'd0, 16'h5555);
    issue(enc_rrr(0, 1, 0, 0), 16'h0022);
    check("r0_read_const", {16'd0, ex_src1}, 32'h0000);
    issue(enc_rri(7, 7, 6, 0), 16'h0023);
    issue(enc_rri(5, 3, 6, 7'h7E), 16'h0024);
    issue(enc_rri(1, 4, 5, 7'h3F), 16'h0025);
    cycle(1'b0, enc_rrr(0, 3, 1, 2), 16'h0026, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);

    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 7) != 0), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    for (int i = 1; i < 8; i++) wr_reg(3'(i), 16'h1111 * 16'(i));
    issue(enc_rri(4, 5, 6, 3), 16'h0030);
    stall = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid",  {31'd0, ex_valid},  32'd0);
    check("rst_src1",   {16'd0, ex_src1},   32'd0);
    check("rst_src2",   {16'd0, ex_src2},   32'd0);
    check("rst_sd",     {16'd0, ex_store_data}, 32'd0);
    check("rst_mem_wr", {31'd0, ex_mem_wr}, 32'd0);
    check("rst_pc",     {16'd0, ex_pc},     32'd0);
    check("rst_tgt",    {29'd0, ex_tgt},    32'd0);
    model_reset();
    stall = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < 8; i++) begin
      issue(enc_rrr(0, 1, i, i), 16'h0040 + 16'(i));
      check("rst_reg_zero", {16'd0, ex_src1}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
